// File: rtl/sram_1r1w_param.sv
// ============================================================================
// sram_1r1w_param : parametrised 1R1W synchronous RAM with clear-on-reset sweep
// Optional stored even parity per entry under `define SRAM_PARITY_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module sram_1r1w_param #(
  parameter int    DATA_WIDTH        = 32,
  parameter int    SIZE              = 64,
  parameter int    ADDR_WIDTH        = (SIZE > 1) ? $clog2(SIZE) : 1,
  parameter string READ_DURING_WRITE = "NEW_DATA",
  parameter int    CLEAR_ON_RESET    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  read_en,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [DATA_WIDTH-1:0] read_data,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic                  init_busy
`ifdef SRAM_PARITY_EN
  ,
  output logic                  parity_err
`endif
);

`ifdef SRAM_PARITY_EN
  localparam int c_MEM_W = DATA_WIDTH + 1;
`else
  localparam int c_MEM_W = DATA_WIDTH;
`endif
  localparam bit                  c_NEW_DATA = (READ_DURING_WRITE == "NEW_DATA");
  localparam logic [ADDR_WIDTH:0] c_SIZE     = (ADDR_WIDTH + 1)'(SIZE);
  localparam logic [ADDR_WIDTH-1:0] c_LAST   = ADDR_WIDTH'(SIZE - 1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] w_cnt_next;

  logic [c_MEM_W-1:0]    r_mem [0:SIZE-1];

  logic                  w_rd_ok;
  logic                  w_wr_ok;
  logic                  w_user_we;
  logic                  w_user_re;
  logic                  w_fwd;
  logic [c_MEM_W-1:0]    w_wr_word;
  logic [c_MEM_W-1:0]    w_rd_word;

  // Range checks only matter for non-power-of-2 SIZE; they fold away otherwise.
  assign w_rd_ok   = ({1'b0, read_addr}  < c_SIZE);
  assign w_wr_ok   = ({1'b0, write_addr} < c_SIZE);
  assign w_user_we = (r_state == ST_RUN) && write_en && w_wr_ok;
  assign w_user_re = (r_state == ST_RUN) && read_en;
  assign w_fwd     = c_NEW_DATA && w_user_we && (write_addr == read_addr);
  assign w_rd_word = w_rd_ok ? r_mem[read_addr] : '0;

`ifdef SRAM_PARITY_EN
  assign w_wr_word = {^write_data, write_data};
`else
  assign w_wr_word = write_data;
`endif

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    if (r_state == ST_INIT) begin
      w_cnt_next = r_cnt + 1'b1;
      if (r_cnt == c_LAST) begin
        w_state_next = ST_RUN;
        w_cnt_next   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
      r_cnt     <= '0;
      init_busy <= (CLEAR_ON_RESET != 0);
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      init_busy <= (w_state_next == ST_INIT);
    end
  end

  // Storage has no reset so it can map onto a RAM macro.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (r_state == ST_INIT) begin
        r_mem[r_cnt] <= '0;
      end else if (w_user_we) begin
        r_mem[write_addr] <= w_wr_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      read_data <= '0;
    end else if (w_user_re) begin
      if (!w_rd_ok) begin
        read_data <= '0;
      end else if (w_fwd) begin
        read_data <= write_data;
      end else begin
        read_data <= w_rd_word[DATA_WIDTH-1:0];
      end
    end
  end

`ifdef SRAM_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      parity_err <= 1'b0;
    end else if (w_user_re) begin
      parity_err <= w_rd_ok && !w_fwd && (^w_rd_word);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_sram_1r1w_param.sv
// ============================================================================
// tb_sram_1r1w_param : directed bench for sram_1r1w_param (NEW_DATA/52, OLD_DATA/64)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sram_1r1w_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        read_en;
  logic [5:0]  read_addr;
  logic        write_en;
  logic [5:0]  write_addr;
  logic [31:0] write_data;
  logic [31:0] rd_a;
  logic [31:0] rd_b;
  logic        busy_a;
  logic        busy_b;
`ifdef SRAM_PARITY_EN
  logic        perr_a;
  logic        perr_b;
`endif

  int total = 0;
  int bad   = 0;
  int n_a;
  int n_b;
  logic [31:0] exp_a [0:51];

  always #5 clk = ~clk;

  sram_1r1w_param #(
    .DATA_WIDTH(32), .SIZE(52), .READ_DURING_WRITE("NEW_DATA"), .CLEAR_ON_RESET(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .read_en(read_en), .read_addr(read_addr), .read_data(rd_a),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data), .init_busy(busy_a)
`ifdef SRAM_PARITY_EN
    , .parity_err(perr_a)
`endif
  );

  sram_1r1w_param #(
    .DATA_WIDTH(32), .SIZE(64), .READ_DURING_WRITE("OLD_DATA"), .CLEAR_ON_RESET(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .read_en(read_en), .read_addr(read_addr), .read_data(rd_b),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data), .init_busy(busy_b)
`ifdef SRAM_PARITY_EN
    , .parity_err(perr_b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [5:0] a, input logic [31:0] d);
    write_en = 1'b1; write_addr = a; write_data = d;
    tick();
    write_en = 1'b0;
  endtask

  task automatic do_read(input logic [5:0] a);
    read_en = 1'b1; read_addr = a;
    tick();
    read_en = 1'b0;
  endtask

  task automatic do_rw(input logic [5:0] wa, input logic [31:0] d, input logic [5:0] ra);
    write_en = 1'b1; write_addr = wa; write_data = d;
    read_en  = 1'b1; read_addr  = ra;
    tick();
    write_en = 1'b0; read_en = 1'b0;
  endtask

  // Counts edges from reset release until each instance drops init_busy.
  task automatic count_sweep(output int na, output int nb, output logic rd_dirty);
    logic da = 1'b0;
    logic db = 1'b0;
    na = 0; nb = 0; rd_dirty = 1'b0;
    for (int c = 0; c < 200 && !(da && db); c++) begin
      tick();
      if (!da) begin
        na++;
        if (rd_a !== 32'h0) rd_dirty = 1'b1;
        if (!busy_a) begin
          da = 1'b1; write_en = 1'b0; read_en = 1'b0;
        end
      end
      if (!db) begin
        nb++;
        if (!busy_b) db = 1'b1;
      end
    end
  endtask

  initial begin
    logic dirty;
    rst_n = 1'b0; read_en = 1'b0; read_addr = '0;
    write_en = 1'b0; write_addr = '0; write_data = '0;
    for (int i = 0; i < 52; i++) exp_a[i] = 32'h0;

    repeat (3) tick();
    check("reset_rd_a", rd_a, 32'h0);
    check("reset_rd_b", rd_b, 32'h0);
    check("reset_busy_a", {31'd0, busy_a}, 32'd1);
    check("reset_busy_b", {31'd0, busy_b}, 32'd1);

    // Accesses attempted during the sweep must be ignored.
    write_en = 1'b1; write_addr = 6'd7; write_data = 32'hFFFF_FFFF;
    read_en = 1'b1; read_addr = 6'd7;
    rst_n = 1'b1;
    count_sweep(n_a, n_b, dirty);
    check("sweep_len_a", n_a, 32'd52);
    check("sweep_len_b", n_b, 32'd64);
    check("sweep_rd_hold_a", {31'd0, dirty}, 32'd0);
    for (int i = 0; i < 52; i++) begin
      do_read(6'(i));
      check($sformatf("sweep_clear_a[%0d]", i), rd_a, 32'h0);
    end

    // Mid-sweep reset: entry 40 is dirtied, then a fresh sweep must clear it.
    do_write(6'd40, 32'h5555_5555);
    do_read(6'd40);
    check("pre_reset_b40", rd_b, 32'h5555_5555);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    repeat (30) tick();
    rst_n = 1'b0; tick();
    check("midreset_busy_b", {31'd0, busy_b}, 32'd1);
    rst_n = 1'b1;
    count_sweep(n_a, n_b, dirty);
    check("resweep_len_a", n_a, 32'd52);
    check("resweep_len_b", n_b, 32'd64);
    for (int i = 0; i < 64; i++) begin
      do_read(6'(i));
      check($sformatf("resweep_clear_b[%0d]", i), rd_b, 32'h0);
    end

    // Basic write/read and hold.
    do_write(6'd5, 32'hDEAD_BEEF); exp_a[5] = 32'hDEAD_BEEF;
    do_read(6'd5);
    check("basic_rd_a", rd_a, 32'hDEAD_BEEF);
    read_addr = 6'd6;
    tick(); tick();
    check("hold_rd_a", rd_a, 32'hDEAD_BEEF);
    check("hold_rd_b", rd_b, 32'hDEAD_BEEF);

    // Same-address collision.
    do_write(6'd9, 32'h1111);
    do_rw(6'd9, 32'h2222, 6'd9); exp_a[9] = 32'h2222;
    check("coll_new_a", rd_a, 32'h2222);
    check("coll_old_b", rd_b, 32'h1111);
    do_read(6'd9);
    check("coll_after_a", rd_a, 32'h2222);
    check("coll_after_b", rd_b, 32'h2222);

    // Different addresses in the same cycle.
    do_rw(6'd10, 32'h3333, 6'd5); exp_a[10] = 32'h3333;
    check("diff_rd_a", rd_a, 32'hDEAD_BEEF);
    check("diff_rd_b", rd_b, 32'hDEAD_BEEF);
    do_read(6'd10);
    check("diff_after_a", rd_a, 32'h3333);

    // Address 60 is out of range for the 52-entry instance only.
    do_rw(6'd60, 32'hABCD, 6'd60);
    check("range_fwd_a", rd_a, 32'h0);
    check("range_old_b", rd_b, 32'h0);
    do_read(6'd60);
    check("range_rd_a", rd_a, 32'h0);
    check("range_rd_b", rd_b, 32'hABCD);
    for (int i = 0; i < 52; i++) begin
      do_read(6'(i));
      check($sformatf("range_keep_a[%0d]", i), rd_a, exp_a[i]);
    end

`ifdef SRAM_PARITY_EN
    do_write(6'd3, 32'h0000_0001);
    do_read(6'd3);
    check("par_clean_a", {31'd0, perr_a}, 32'd0);
    dut_a.r_mem[3][32] = ~dut_a.r_mem[3][32];
    do_read(6'd3);
    check("par_err_a", {31'd0, perr_a}, 32'd1);
    check("par_data_a", rd_a, 32'h0000_0001);
    do_read(6'd4);
    check("par_clear_a", {31'd0, perr_a}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
